// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencer: condition codes,
// flag bit positions in the {Z,N,V,C} vector and FSM state encoding.
package branch_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_NV = 4'hE;
    localparam logic [3:0] COND_AL = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLAG_WAIT = 2'd1,
        ST_REDIRECT  = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports: cond (4-bit code), flags ({Z,N,V,C}) -> taken.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic z, n, v, c;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = ~(n ^ v);
            COND_LT: taken = n ^ v;
            COND_GT: taken = ~z & ~(n ^ v);
            COND_LE: taken = z | (n ^ v);
            COND_NV: taken = 1'b0;
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: owns the {Z,N,V,C} flag register, resolves the D-stage
// branch and its flag hazard against E, and drives PC redirect, F/D stall
// and D/E flush strobes.
// Ports: clk, rst (sync, active-high), hold (freeze), branch_d,
// branch_condition_d, branch_target_d, flag_we_e, alu_flags_e ->
// pc_source, pc_target, stall_fd, flush_d, flush_e, flags.
// Option: BRANCH_FLAG_FWD_EN forwards E flags to the condition evaluation
// and removes the flag-hazard stall.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            branch_d,
    input  logic [3:0]      branch_condition_d,
    input  logic [PC_W-1:0] branch_target_d,
    input  logic            flag_we_e,
    input  logic [3:0]      alu_flags_e,
    output logic            pc_source,
    output logic [PC_W-1:0] pc_target,
    output logic            stall_fd,
    output logic            flush_d,
    output logic            flush_e,
    output logic [3:0]      flags
);

    state_t     state;
    state_t     state_nxt;
    logic       hazard;
    logic       taken;
    logic       capture;
    logic [3:0] eval_flags;

`ifdef BRANCH_FLAG_FWD_EN
    assign hazard = 1'b0;

    // Flags being written this cycle are the ones the branch must see.
    always_comb begin
        eval_flags = flags;
        if (state == ST_RUN && flag_we_e)
            eval_flags = alu_flags_e;
    end
`else
    assign hazard = branch_d & flag_we_e &
                    (branch_condition_d != COND_AL) &
                    (state == ST_RUN);

    // In FLAG_WAIT the register already holds the flags the branch needs.
    assign eval_flags = flags;
`endif

    branch_cond_eval u_cond (
        .cond  (branch_condition_d),
        .flags (eval_flags),
        .taken (taken)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch_d) begin
                    if (hazard) begin
                        state_nxt = ST_FLAG_WAIT;
                    end else if (taken) begin
                        capture   = 1'b1;
                        state_nxt = ST_REDIRECT;
                    end
                end
            end
            ST_FLAG_WAIT: begin
                if (taken) begin
                    capture   = 1'b1;
                    state_nxt = ST_REDIRECT;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            // Whatever sits in D here is wrong-path and gets flushed.
            ST_REDIRECT: state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
    end

    assign pc_source = (state == ST_REDIRECT);
    assign flush_d   = (state == ST_REDIRECT);
    assign flush_e   = (state == ST_REDIRECT) | hazard;
    assign stall_fd  = hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flags     <= 4'b0000;
            pc_target <= '0;
        end else if (!hold) begin
            state <= state_nxt;
            if (capture)
                pc_target <= branch_target_d;
            if (flag_we_e)
                flags <= alu_flags_e;
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: directed scenarios followed by
// random traffic, checked against a behavioural model of the pipeline.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        branch_d;
    logic [3:0]  branch_condition_d;
    logic [15:0] branch_target_d;
    logic        flag_we_e;
    logic [3:0]  alu_flags_e;
    logic        pc_source;
    logic [15:0] pc_target;
    logic        stall_fd;
    logic        flush_d;
    logic        flush_e;
    logic [3:0]  flags;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.PC_W(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .hold               (hold),
        .branch_d           (branch_d),
        .branch_condition_d (branch_condition_d),
        .branch_target_d    (branch_target_d),
        .flag_we_e          (flag_we_e),
        .alu_flags_e        (alu_flags_e),
        .pc_source          (pc_source),
        .pc_target          (pc_target),
        .stall_fd           (stall_fd),
        .flush_d            (flush_d),
        .flush_e            (flush_e),
        .flags              (flags)
    );

    // Expected vector: {pc_source, pc_target, stall_fd, flush_d, flush_e, flags}
    typedef logic [23:0] obs_t;
    obs_t exp_q[$];

    // Model: "known" once a reset has been seen; a redirect is due this
    // cycle, or a stalled branch is waiting for its flags.
    bit          known = 0;
    bit          redir_now = 0;
    bit          waiting = 0;
    logic [15:0] m_tgt = 16'h0;
    logic [3:0]  m_fl = 4'h0;

    function automatic bit cond_true(input logic [3:0] cc, input logic [3:0] f);
        bit z, n, v, c;
        z = f[3]; n = f[2]; v = f[1]; c = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic bit model_hazard();
`ifdef BRANCH_FLAG_FWD_EN
        return 0;
`else
        return !redir_now && !waiting && branch_d && flag_we_e &&
               branch_condition_d != 4'hF;
`endif
    endfunction

    // Advance the model across one rising edge using the inputs of the
    // cycle that is ending.
    task automatic model_edge();
        bit hz;
        bit tk;
        logic [3:0] f;
        hz = model_hazard();
        if (rst) begin
            known = 1; redir_now = 0; waiting = 0;
            m_tgt = 16'h0; m_fl = 4'h0;
        end else if (known && !hold) begin
            if (redir_now) begin
                redir_now = 0;
            end else if (waiting) begin
                waiting = 0;
                if (cond_true(branch_condition_d, m_fl)) begin
                    redir_now = 1; m_tgt = branch_target_d;
                end
            end else if (branch_d) begin
                if (hz) begin
                    waiting = 1;
                end else begin
                    f = m_fl;
`ifdef BRANCH_FLAG_FWD_EN
                    if (flag_we_e) f = alu_flags_e;
`endif
                    tk = cond_true(branch_condition_d, f);
                    if (tk) begin
                        redir_now = 1; m_tgt = branch_target_d;
                    end
                end
            end
            if (flag_we_e) m_fl = alu_flags_e;
        end
    endtask

    task automatic push_expect();
        bit hz;
        if (!known) return;
        hz = model_hazard();
        exp_q.push_back({redir_now, m_tgt, hz, redir_now, redir_now | hz, m_fl});
    endtask

    // One clock cycle of stimulus: apply inputs just after the edge.
    task automatic cycle(input bit r, input bit h, input bit br,
                         input logic [3:0] cc, input logic [15:0] tg,
                         input bit we, input logic [3:0] al);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; hold = h; branch_d = br; branch_condition_d = cc;
        branch_target_d = tg; flag_we_e = we; alu_flags_e = al;
        cyc++;
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, 4'h0, 16'h0, 0, 4'h0);
    endtask

    initial begin : monitor
        obs_t got;
        obs_t want;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got = {pc_source, pc_target, stall_fd, flush_d, flush_e, flags};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL cycle%0d outputs got=%h want=%h (ps,tgt,st,fd,fe,fl)",
                             cyc, got, want);
                end
            end
        end
    end

    initial begin : driver
        rst = 1; hold = 0; branch_d = 0; branch_condition_d = 0;
        branch_target_d = 0; flag_we_e = 0; alu_flags_e = 0;
        cycle(1, 0, 0, 4'h0, 16'h0, 0, 4'h0);
        cycle(1, 1, 0, 4'h0, 16'h0, 0, 4'h0);
        idle(2);
        cycle(0, 1, 0, 4'h0, 16'h0, 0, 4'h0);
        cycle(0, 1, 0, 4'h0, 16'h0, 0, 4'h0);
        idle(1);
        // Z=1, then a taken EQ branch to 0x0040
        cycle(0, 0, 0, 4'h0, 16'h0, 1, 4'b1000);
        cycle(0, 0, 1, 4'h0, 16'h0040, 0, 4'h0);
        idle(3);
        // NE with flags being written (hazard unless forwarding)
        cycle(0, 0, 1, 4'h1, 16'h0080, 1, 4'b0000);
        cycle(0, 0, 1, 4'h1, 16'h0080, 0, 4'h0);
        idle(3);
        // AL with a flag write: never stalls
        cycle(0, 0, 1, 4'hF, 16'h00C0, 1, 4'b0101);
        idle(2);
        // NV: stalls on a hazard but never redirects
        cycle(0, 0, 1, 4'hE, 16'h00D0, 1, 4'b1111);
        cycle(0, 0, 1, 4'hE, 16'h00D0, 0, 4'h0);
        idle(2);
        // Back-to-back: the second branch lands in REDIRECT
        cycle(0, 0, 1, 4'hF, 16'h0100, 0, 4'h0);
        cycle(0, 0, 1, 4'hF, 16'h0200, 0, 4'h0);
        idle(2);
        // hold for 3 cycles during REDIRECT
        cycle(0, 0, 1, 4'hF, 16'h0300, 0, 4'h0);
        cycle(0, 1, 0, 4'h0, 16'h0, 1, 4'b0011);
        cycle(0, 1, 0, 4'h0, 16'h0, 0, 4'h0);
        cycle(0, 1, 0, 4'h0, 16'h0, 0, 4'h0);
        idle(2);
        // rst during REDIRECT (with hold) wins
        cycle(0, 0, 1, 4'hF, 16'h0400, 0, 4'h0);
        cycle(1, 1, 0, 4'h0, 16'h0, 0, 4'h0);
        idle(2);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0),
                  4'($urandom_range(0, 15)),
                  16'($urandom),
                  ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain queue_left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
